vga_plot_arbiter: RTL

- Shares the single pixel-write port of vga_adapter (x, y, colour, plot) between NUM_REQ drawing engines: maze drawer, player sprite, HUD/score.
- Each engine requests the port, receives an exclusive grant, streams pixels, and releases on a last-pixel flag.
- Round-robin arbitration with a stall watchdog, so a hung engine cannot lock the framebuffer.
- Sits between the drawing engines and vga_adapter in the top level; it replaces the direct KEY-driven plot wiring.

---
 rtl/vga_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/vga_plot_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared screen constants, widths and arbiter state encodings
// for the VGA pixel-port sharing logic.
package vga_pkg;

  localparam int SCR_W     = 320;
  localparam int SCR_H     = 240;
  localparam int XW        = 9;
  localparam int YW        = 8;
  localparam int CW        = 3;
  localparam int NUM_REQ   = 3;
  localparam int WD_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selector: first request at or after
// the pointer, wrapping, as a one-hot choice plus its index.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW-1:0] cand;
  logic          found;

  // Walk requesters starting at ptr_i; keep the first hit
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter pixel-write port between drawing
// engines: round-robin grants, burst streaming, stall watchdog.
module vga_plot_arbiter #(
  parameter int NUM_REQ   = vga_pkg::NUM_REQ,
  parameter int XW        = vga_pkg::XW,
  parameter int YW        = vga_pkg::YW,
  parameter int CW        = vga_pkg::CW,
  parameter int WD_CYCLES = vga_pkg::WD_CYCLES
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*XW-1:0] px_x,
  input  logic [NUM_REQ*YW-1:0] px_y,
  input  logic [NUM_REQ*CW-1:0] px_colour,
  input  logic [NUM_REQ-1:0]    px_valid,
  input  logic [NUM_REQ-1:0]    px_last,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [XW-1:0]         vga_x,
  output logic [YW-1:0]         vga_y,
  output logic [CW-1:0]         vga_colour,
  output logic                  plot,
  output logic                  busy,
  output logic                  wd_fired,
  output logic [15:0]           pix_count
);

  import vga_pkg::*;

  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(WD_CYCLES - 1);
  localparam logic [PW-1:0] G_MAX   = PW'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]        g_q, g_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [CW-1:0]        c_q, c_d;
  logic                 plot_q, plot_d;
  logic                 wdf_q, wdf_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [WW-1:0]        wd_q, wd_d;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic [PW-1:0]        ptr_nxt;
  logic                 vld, lst;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign vld     = px_valid[g_q];
  assign lst     = px_last[g_q];
  assign ptr_nxt = (g_q == G_MAX) ? '0 : g_q + 1'b1;

  // Next-state and registered-output decisions
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
    wdf_d   = 1'b0;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          g_d     = pick_idx;
          cnt_d   = '0;
          wd_d    = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (vld) begin
          plot_d = 1'b1;
          x_d    = px_x[int'(g_q)*XW +: XW];
          y_d    = px_y[int'(g_q)*YW +: YW];
          c_d    = px_colour[int'(g_q)*CW +: CW];
          cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          wd_d   = '0;
          if (lst) begin
            gnt_d   = '0;
            ptr_d   = ptr_nxt;
            state_d = ST_RELEASE;
          end
        end else if (wd_q == WD_LAST) begin
          gnt_d   = '0;
          wdf_d   = 1'b1;
          ptr_d   = ptr_nxt;
          state_d = ST_RELEASE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      wdf_q   <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      wdf_q   <= wdf_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign gnt        = gnt_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = c_q;
  assign plot       = plot_q;
  assign busy       = (state_q == ST_GRANT);
  assign wd_fired   = wdf_q;
  assign pix_count  = cnt_q;

endmodule
